tcb_sub_mem: RTL and testbench

Synthesizable TCB subordinate: byte-addressable on-chip memory that answers TCB requests with a fixed response latency of DLY cycles. It is the RTL counterpart of the TCB manager VIP, placed at the far end of a TCB bus as instruction/data RAM or a scratchpad. It checks request legality (size, alignment, range) and reports violations on the error response bit.

---
 rtl/tcb_pkg.sv | 28 ++
 rtl/tcb_sub_mem_if.sv | 32 +++
 rtl/tcb_sub_dly.sv | 51 +++++
 rtl/tcb_sub_mem.sv | 125 ++++++++++++
 tb/tb_tcb_sub_mem.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/tcb_pkg.sv
// -----------------------------------------------------------------------------
// tcb_pkg
// Shared TCB definitions: transfer size encoding, error response values and
// an address alignment helper used by TCB subordinates.
// No ports (package).
// -----------------------------------------------------------------------------
package tcb_pkg;

    // log2 of the transfer size in bytes, as carried on tcb_siz
    typedef enum logic [1:0] {
        TCB_SIZ_BYTE = 2'd0,
        TCB_SIZ_HALF = 2'd1,
        TCB_SIZ_WORD = 2'd2,
        TCB_SIZ_DWRD = 2'd3
    } tcb_siz_t;

    // error response bit values
    localparam logic TCB_ERR_OK  = 1'b0;
    localparam logic TCB_ERR_BAD = 1'b1;

    // True when adr is a multiple of 2**siz.
    function automatic logic tcb_aligned(input logic [63:0] adr, input logic [5:0] siz);
        logic [63:0] mask;
        mask = (64'd1 << siz) - 64'd1;
        return (adr & mask) == 64'd0;
    endfunction

endpackage

// File: rtl/tcb_sub_mem_if.sv
// -----------------------------------------------------------------------------
// tcb_sub_mem_if
// TCB request/response bundle between a manager and tcb_sub_mem.
// Signals:
//   vld  request valid          rdy  request ready
//   wen  write enable           adr  byte address (ABW)
//   siz  log2 transfer size     ben  byte enables (BEW)
//   wdt  write data (DBW)       rdt  read data (DBW)
//   err  error response
// Modports: master drives the request, slave drives rdy and the response.
// -----------------------------------------------------------------------------
interface tcb_sub_mem_if #(
    parameter int unsigned ABW = 32,
    parameter int unsigned DBW = 32,
    parameter int unsigned SLW = 8,
    parameter int unsigned BEW = DBW / SLW
) ();
    localparam int unsigned SZW = $clog2($clog2(BEW) + 1);

    logic           vld;
    logic           rdy;
    logic           wen;
    logic [ABW-1:0] adr;
    logic [SZW-1:0] siz;
    logic [BEW-1:0] ben;
    logic [DBW-1:0] wdt;
    logic [DBW-1:0] rdt;
    logic           err;

    modport master (output vld, wen, adr, siz, ben, wdt, input  rdy, rdt, err);
    modport slave  (input  vld, wen, adr, siz, ben, wdt, output rdy, rdt, err);
endinterface

// File: rtl/tcb_sub_dly.sv
// -----------------------------------------------------------------------------
// tcb_sub_dly
// Response delay line of DLY stages. Each stage loads only when the stage in
// front of it carries a valid response, so the output holds the last response
// until the next one arrives. DLY = 0 is a plain wire.
// Ports:
//   clk   clock
//   rst   synchronous reset, active-low
//   vld   input response valid
//   din   input response data (WIDTH)
//   dout  delayed response data (WIDTH), held between responses
//   dvld  strobe: dout took a new value this cycle
// -----------------------------------------------------------------------------
module tcb_sub_dly #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DLY   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dvld
);

    if (DLY == 0) begin : g_pass
        assign dout = din;
        assign dvld = vld;
    end else begin : g_pipe
        logic [DLY-1:0]   vld_q;
        logic [WIDTH-1:0] dat_q [DLY];

        always_ff @(posedge clk) begin
            if (!rst) begin
                vld_q <= '0;
                for (int i = 0; i < int'(DLY); i++) dat_q[i] <= '0;
            end else begin
                vld_q[0] <= vld;
                if (vld) dat_q[0] <= din;
                for (int i = 1; i < int'(DLY); i++) begin
                    vld_q[i] <= vld_q[i-1];
                    if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
                end
            end
        end

        assign dout = dat_q[DLY-1];
        assign dvld = vld_q[DLY-1];
    end

endmodule

// File: rtl/tcb_sub_mem.sv
// -----------------------------------------------------------------------------
// tcb_sub_mem
// TCB subordinate: byte-addressable on-chip RAM answering every request with
// a fixed latency of DLY cycles. Illegal requests (size too large, misaligned,
// out of range) leave the memory untouched and respond with err = 1, rdt = 0.
// Ports:
//   clk   clock
//   rst   synchronous reset, active-low
//   tcb   TCB slave port (vld/rdy/wen/adr/siz/ben/wdt in, rdt/err out)
// -----------------------------------------------------------------------------
module tcb_sub_mem
    import tcb_pkg::*;
#(
    parameter int unsigned ABW = 32,
    parameter int unsigned DBW = 32,
    parameter int unsigned SLW = 8,
    parameter int unsigned BEW = DBW / SLW,
    parameter int unsigned DLY = 1,
    parameter int unsigned SIZ = 4096
) (
    input  logic          clk,
    input  logic          rst,
    tcb_sub_mem_if.slave  tcb
);

    localparam int unsigned BYW = $clog2(BEW);  // byte offset bits
    localparam int unsigned AW  = $clog2(SIZ);  // in-range address bits
    localparam int unsigned DEP = SIZ / BEW;    // words

    if ((DLY < 1) || (DLY > 4)) begin : g_bad_dly
        $error("tcb_sub_mem: DLY must be in 1..4");
    end
    if ((SIZ != (1 << AW)) || (SIZ % BEW != 0)) begin : g_bad_siz
        $error("tcb_sub_mem: SIZ must be a power of two and a multiple of BEW");
    end

    // ready: low while in reset, high from the cycle after reset release
    logic rdy_q;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values and simulation matches the hardware.
    always_ff @(posedge clk) begin
        if (!rst) rdy_q <= 1'b0;
        else      rdy_q <= 1'b1;
    end

    assign tcb.rdy = rdy_q;

    // request legality
    logic              trn;
    logic              req_err;
    logic [AW-BYW-1:0] idx;

    assign trn     = tcb.vld & rdy_q;
    assign idx     = tcb.adr[AW-1:BYW];
    assign req_err = (32'(tcb.siz) > BYW)
                   | !tcb_aligned(64'(tcb.adr), 6'(tcb.siz))
                   | ((tcb.adr >> AW) != '0);

    // RAM with per-byte write and registered read
    logic [DBW-1:0] mem [DEP];
    logic [DBW-1:0] ram_q;

    // NOTE: the RAM array and its read register are deliberately not reset;
    // contents survive reset and map onto plain memory macros.
    always_ff @(posedge clk) begin
        if (trn && tcb.wen && !req_err) begin
            for (int n = 0; n < int'(BEW); n++) begin
                if (tcb.ben[n]) mem[idx][n*SLW +: SLW] <= tcb.wdt[n*SLW +: SLW];
            end
        end
        if (trn && !tcb.wen) ram_q <= mem[idx];
    end

    // stage-1 control: ben_q doubles as the read-lane mask, cleared for
    // writes and errors so those responses return rdt = 0
    logic           vld_q;
    logic           err_q;
    logic [BEW-1:0] ben_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= 1'b0;
            err_q <= TCB_ERR_OK;
            ben_q <= '0;
        end else begin
            vld_q <= trn;
            if (trn) begin
                err_q <= req_err ? TCB_ERR_BAD : TCB_ERR_OK;
                ben_q <= (tcb.wen || req_err) ? '0 : tcb.ben;
            end
        end
    end

    logic [DBW-1:0] rdt_s1;

    // NOTE: outputs of combinational processes get a default first so no
    // path leaves them unassigned and no latch is inferred.
    always_comb begin
        rdt_s1 = '0;
        for (int n = 0; n < int'(BEW); n++) begin
            if (ben_q[n]) rdt_s1[n*SLW +: SLW] = ram_q[n*SLW +: SLW];
        end
    end

    // stages 2..DLY
    logic [DBW:0] rsp;
    logic         rsp_vld_unused;

    tcb_sub_dly #(
        .WIDTH (DBW + 1),
        .DLY   (DLY - 1)
    ) u_dly (
        .clk  (clk),
        .rst  (rst),
        .vld  (vld_q),
        .din  ({err_q, rdt_s1}),
        .dout (rsp),
        .dvld (rsp_vld_unused)
    );

    assign tcb.rdt = rsp[DBW-1:0];
    assign tcb.err = rsp[DBW];

endmodule

// File: tb/tb_tcb_sub_mem.sv
// -----------------------------------------------------------------------------
// tb_tcb_sub_mem
// Drives one directed request stream into four tcb_sub_mem instances with
// DLY = 1, 2, 3, 4 and checks each one's rdy/rdt/err every cycle against the
// hand-computed response that must be visible at that instance's latency.
// -----------------------------------------------------------------------------
module tb_tcb_sub_mem;
    import tcb_pkg::*;

    localparam int NDUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vld = 1'b0;
    logic        wen = 1'b0;
    logic [31:0] adr = '0;
    logic [1:0]  siz = '0;
    logic [3:0]  ben = '0;
    logic [31:0] wdt = '0;

    logic        o_rdy [NDUT];
    logic        o_err [NDUT];
    logic [31:0] o_rdt [NDUT];

    always #5 clk = ~clk;

    for (genvar i = 0; i < NDUT; i++) begin : g_dut
        tcb_sub_mem_if #(.ABW(32), .DBW(32), .SLW(8)) bus ();

        assign bus.vld = vld;
        assign bus.wen = wen;
        assign bus.adr = adr;
        assign bus.siz = siz;
        assign bus.ben = ben;
        assign bus.wdt = wdt;

        tcb_sub_mem #(
            .ABW(32), .DBW(32), .SLW(8), .BEW(4), .DLY(i + 1), .SIZ(4096)
        ) dut (
            .clk (clk),
            .rst (rst),
            .tcb (bus)
        );

        assign o_rdy[i] = bus.rdy;
        assign o_err[i] = bus.err;
        assign o_rdt[i] = bus.rdt;
    end

    // expected responses, tagged with the edge at which the request transferred
    typedef struct {
        int          e;
        logic        err;
        logic [31:0] rdt;
    } rsp_t;

    rsp_t        rq [$];
    int          ptr      [NDUT];
    logic        held_err [NDUT];
    logic [31:0] held_rdt [NDUT];
    logic        exp_rdy;
    int          cyc        = 0;
    int          compared   = 0;
    int          mismatched = 0;

    task automatic check();
        for (int i = 0; i < NDUT; i++) begin
            compared++;
            assert (o_rdy[i] === exp_rdy) else begin
                mismatched++;
                $error("FAIL rdy dly%0d cyc%0d: observed %b expected %b", i + 1, cyc, o_rdy[i], exp_rdy);
            end
            compared++;
            assert (o_err[i] === held_err[i]) else begin
                mismatched++;
                $error("FAIL err dly%0d cyc%0d: observed %b expected %b", i + 1, cyc, o_err[i], held_err[i]);
            end
            compared++;
            assert (o_rdt[i] === held_rdt[i]) else begin
                mismatched++;
                $error("FAIL rdt dly%0d cyc%0d: observed %h expected %h", i + 1, cyc, o_rdt[i], held_rdt[i]);
            end
        end
    endtask

    // One clock cycle: drive a request (or idle), advance the expected
    // response of every instance, then compare just after the edge.
    task automatic step(input logic v, input logic w, input logic [31:0] a, input logic [1:0] s,
                        input logic [3:0] b, input logic [31:0] d, input logic ee, input logic [31:0] er);
        vld = v; wen = w; adr = a; siz = s; ben = b; wdt = d;
        @(posedge clk);
        cyc++;
        if (!rst) begin
            for (int i = 0; i < NDUT; i++) begin
                ptr[i]      = rq.size();
                held_err[i] = 1'b0;
                held_rdt[i] = 32'h0;
            end
        end else if (v) begin
            rq.push_back('{e: cyc, err: ee, rdt: er});
        end
        exp_rdy = rst;
        for (int i = 0; i < NDUT; i++) begin
            while (ptr[i] < rq.size() && rq[ptr[i]].e + i <= cyc) begin
                held_err[i] = rq[ptr[i]].err;
                held_rdt[i] = rq[ptr[i]].rdt;
                ptr[i]++;
            end
        end
        #1;
        check();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 32'h0, 2'd0, 4'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d, input logic ee);
        step(1'b1, 1'b1, a, TCB_SIZ_WORD, b, d, ee, 32'h0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [1:0] s, input logic [3:0] b,
                      input logic ee, input logic [31:0] er);
        step(1'b1, 1'b0, a, s, b, 32'h0, ee, er);
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [1:0]  s;
        logic [3:0]  b;
        logic [31:0] d;
        logic        ee;
        logic [31:0] er;
        int          gap;
    } vec_t;

    vec_t bb [18];

    initial begin
        // reset state, then release
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(1);

        // full-word write then read
        wr(32'h000, 4'hF, 32'h01234567, 1'b0);
        rd(32'h000, TCB_SIZ_WORD, 4'hF, 1'b0, 32'h01234567);
        idle(4);

        // partial write and masked reads
        wr(32'h004, 4'hF, 32'hAABBCCDD, 1'b0);
        wr(32'h004, 4'b0010, 32'h00001100, 1'b0);
        rd(32'h004, TCB_SIZ_WORD, 4'hF, 1'b0, 32'hAABB11DD);
        rd(32'h004, TCB_SIZ_WORD, 4'b0011, 1'b0, 32'h000011DD);
        idle(4);

        // misalignment
        wr(32'h010, 4'hF, 32'h55667788, 1'b0);
        rd(32'h011, TCB_SIZ_WORD, 4'hF, 1'b1, 32'h0);
        wr(32'h011, 4'hF, 32'hFFFFFFFF, 1'b1);
        rd(32'h010, TCB_SIZ_WORD, 4'hF, 1'b0, 32'h55667788);
        rd(32'h003, TCB_SIZ_HALF, 4'b1100, 1'b1, 32'h0);
        idle(4);

        // range, size and sub-word boundaries
        wr(32'h1000, 4'hF, 32'hDEADBEEF, 1'b1);
        rd(32'h000, TCB_SIZ_WORD, 4'hF, 1'b0, 32'h01234567);
        rd(32'h000, TCB_SIZ_DWRD, 4'hF, 1'b1, 32'h0);
        rd(32'h002, TCB_SIZ_HALF, 4'b1100, 1'b0, 32'h01230000);
        rd(32'h007, TCB_SIZ_BYTE, 4'b1000, 1'b0, 32'hAA000000);
        wr(32'hFFC, 4'hF, 32'h13579BDF, 1'b0);
        rd(32'hFFC, TCB_SIZ_WORD, 4'hF, 1'b0, 32'h13579BDF);
        idle(5);

        // back-to-back stream with idle gaps
        bb = '{
            '{1'b1, 32'h020, 2'd2, 4'hF, 32'h11111111, 1'b0, 32'h00000000, 0},
            '{1'b1, 32'h024, 2'd2, 4'hF, 32'h22222222, 1'b0, 32'h00000000, 0},
            '{1'b0, 32'h020, 2'd2, 4'hF, 32'h00000000, 1'b0, 32'h11111111, 1},
            '{1'b0, 32'h024, 2'd2, 4'hF, 32'h00000000, 1'b0, 32'h22222222, 0},
            '{1'b1, 32'h020, 2'd2, 4'h1, 32'h000000AA, 1'b0, 32'h00000000, 2},
            '{1'b0, 32'h020, 2'd2, 4'hF, 32'h00000000, 1'b0, 32'h111111AA, 0},
            '{1'b1, 32'h028, 2'd2, 4'hF, 32'h33333333, 1'b0, 32'h00000000, 0},
            '{1'b0, 32'h028, 2'd2, 4'hC, 32'h00000000, 1'b0, 32'h33330000, 1},
            '{1'b0, 32'h011, 2'd2, 4'hF, 32'h00000000, 1'b1, 32'h00000000, 0},
            '{1'b1, 32'h024, 2'd2, 4'h8, 32'hBB000000, 1'b0, 32'h00000000, 0},
            '{1'b0, 32'h024, 2'd2, 4'hF, 32'h00000000, 1'b0, 32'hBB222222, 2},
            '{1'b0, 32'h020, 2'd2, 4'h6, 32'h00000000, 1'b0, 32'h00111100, 0},
            '{1'b1, 32'h02C, 2'd2, 4'hF, 32'h44444444, 1'b0, 32'h00000000, 1},
            '{1'b0, 32'h02C, 2'd2, 4'hF, 32'h00000000, 1'b0, 32'h44444444, 0},
            '{1'b0, 32'h1000, 2'd2, 4'hF, 32'h00000000, 1'b1, 32'h00000000, 0},
            '{1'b1, 32'h028, 2'd2, 4'h3, 32'h0000CDEF, 1'b0, 32'h00000000, 0},
            '{1'b0, 32'h028, 2'd2, 4'hF, 32'h00000000, 1'b0, 32'h3333CDEF, 1},
            '{1'b0, 32'h022, 2'd1, 4'hC, 32'h00000000, 1'b0, 32'h11110000, 0}
        };
        for (int k = 0; k < 18; k++) begin
            step(1'b1, bb[k].w, bb[k].a, bb[k].s, bb[k].b, bb[k].d, bb[k].ee, bb[k].er);
            idle(bb[k].gap);
        end
        idle(5);

        // reset with two reads in flight
        rd(32'h000, TCB_SIZ_WORD, 4'hF, 1'b0, 32'h01234567);
        rd(32'h004, TCB_SIZ_WORD, 4'hF, 1'b0, 32'hAABB11DD);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        idle(1);
        rd(32'h004, TCB_SIZ_WORD, 4'hF, 1'b0, 32'hAABB11DD);
        rd(32'h000, TCB_SIZ_WORD, 4'hF, 1'b0, 32'h01234567);
        rd(32'hFFC, TCB_SIZ_WORD, 4'hF, 1'b0, 32'h13579BDF);
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
